tetris_board_renderer: RTL and testbench
========================================

Name: tetris_board_renderer

Overview:
- Pixel source feeding the VGA timing core.
- Consumes the core's registered scan coordinates and returns a 12-bit colour word with a fixed 2-cycle latency.
- Holds the 10x20 Tetris board twice:
  - a shadow board, written by game logic;
  - a display board, rendered on screen.
- Copies shadow to display during vertical blanking on request, so a frame never shows a half-updated board.

Parameters:
- NATIVE_VRES, 480, first non-visible line; blank-time copy trigger.
- X0, 220, playfield left edge in pixels.
- Y0, 40, playfield top edge in pixels.
- CELL_PX, 20, cell edge length in pixels; playfield is 10*CELL_PX by 20*CELL_PX.
- BORDER_PX, 4, border thickness around the playfield.

Ports:
- clk_25_175  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- hpos  in  10  horizontal scan coordinate from the timing core.
- vpos  in  10  vertical scan coordinate from the timing core.
- pixstream  out  12  colour; [3:0]=r, [7:4]=g, [11:8]=b.
- wr_en  in  1  shadow-board cell write strobe.
- wr_col  in  4  cell column, 0..9.
- wr_row  in  5  cell row, 0..19 (0 = top).
- wr_color  in  3  palette index for the cell.
- wr_ready  out  1  a write is accepted only when wr_en and wr_ready are both high.
- commit  in  1  single-cycle request to publish the shadow board.
- commit_busy  out  1  high from an accepted commit (or reset) until the copy finishes.
- frame_done  out  1  one-cycle pulse on the cycle after the last copy write.

Behaviour:
- Async reset (reset=0) forces:
  - pixstream=0, wr_ready=0, commit_busy=1, frame_done=0;
  - FSM to CLEAR, copy index=0.
- FSM states:
  - CLEAR: zeroes entry idx of both boards each cycle, idx 0..199; idx 199 goes to IDLE. Lasts 200 cycles after reset release.
  - IDLE: wr_ready=1, commit_busy=0. commit=1 goes to PENDING.
  - PENDING: wr_ready=0, commit_busy=1. Waits until sampled vpos==NATIVE_VRES and hpos==0, then goes to COPY with idx=0.
  - COPY: copies display[idx]<=shadow[idx], idx 0..199, one cell per cycle. After idx 199, frame_done=1 for one cycle; the next state is IDLE.
- commit while in CLEAR, PENDING or COPY is ignored; no queuing.
- Cell index is row*10+col, range 0..199.
- Writes: accepted when wr_en&wr_ready and wr_col<10 and wr_row<20. Out-of-range writes are silently dropped.
- A write and a commit in the same IDLE cycle: the write lands first, then the commit takes effect.
- Rendering pipeline, for coordinates sampled at cycle t:
  - stage 1 (t+1) registers region class, cell index and in-cell offsets;
  - stage 2 (t+2) reads the display board, applies the palette and registers pixstream.
- The pipeline runs in every state; COPY only occurs while vpos>=NATIVE_VRES, so there is no read/write conflict on visible lines.
- Region priority, with x=hpos, y=vpos:
  - Playfield: X0<=x<X0+200 and Y0<=y<Y0+400. col=(x-X0)/CELL_PX, row=(y-Y0)/CELL_PX.
    - In-cell offset x==0 or y==0: grid colour 12'h333.
    - Otherwise: palette[display[cell]].
  - Border: inside the rectangle expanded by BORDER_PX on all sides but not in the playfield: 12'h888.
  - Elsewhere: 12'h000.
- Palette (12-bit packed b,g,r):
  - 0 = 000 (empty), 1 = FF0 cyan, 2 = 0FF yellow, 3 = 808 purple;
  - 4 = 0F0 green, 5 = 00F red, 6 = F00 blue, 7 = 08F orange.
- Cell/offset arithmetic is correct for arbitrary hpos/vpos, not only sequential scans. Widths are 10-bit unsigned; subtractions happen only inside the range checks.
- Reset asserted mid-COPY: copy aborts; both boards are re-cleared via CLEAR.

Test Plan:
- Reset release → wr_ready low for exactly 200 cycles; pixstream at (X0+5,Y0+5) = 12'h000; commit_busy falls with wr_ready rising.
- Write col=3,row=2,color=5, commit, run to vpos=480/hpos=0 → COPY for 200 cycles, frame_done pulse. Next frame (X0+65,Y0+45) gives 12'h00F two cycles after coordinates; (X0+60,Y0+45) gives 12'h333.
- Write cell, no commit → display unchanged for a full frame: pixel stays 12'h000.
- Coordinates (X0-1,Y0+10) → 12'h888; (X0-5,Y0+10) → 12'h000; (X0+199,Y0+399) → palette of cell 199.
- Writes with col=10 or row=20 → dropped; a commit at the same time as a write → the write is visible after the copy; a second commit during PENDING → exactly one frame_done.
- Assert reset at copy idx 100 → all outputs at reset values immediately; after CLEAR all cells render 000 or grid.

Source files
------------

// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer: double-buffered 10x20 Tetris board rendered as a 2-cycle-latency pixel source.
// The shadow board is published to the display board during vertical blanking, so no frame tears.
module tetris_board_renderer #(
  parameter int NATIVE_VRES = 480,
  parameter int X0 = 220,
  parameter int Y0 = 40,
  parameter int CELL_PX = 20,
  parameter int BORDER_PX = 4
) (
  input  logic        clk_25_175,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic [11:0] pixstream,
  input  logic        wr_en,
  input  logic [3:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [2:0]  wr_color,
  output logic        wr_ready,
  input  logic        commit,
  output logic        commit_busy,
  output logic        frame_done
);
  localparam logic [9:0] PX0 = 10'(X0);
  localparam logic [9:0] PX1 = 10'(X0 + 10 * CELL_PX);
  localparam logic [9:0] PY0 = 10'(Y0);
  localparam logic [9:0] PY1 = 10'(Y0 + 20 * CELL_PX);
  localparam logic [9:0] BX0 = 10'(X0 - BORDER_PX);
  localparam logic [9:0] BX1 = 10'(X0 + 10 * CELL_PX + BORDER_PX);
  localparam logic [9:0] BY0 = 10'(Y0 - BORDER_PX);
  localparam logic [9:0] BY1 = 10'(Y0 + 20 * CELL_PX + BORDER_PX);
  localparam logic [9:0] VRES = 10'(NATIVE_VRES);
  localparam logic [9:0] CP = 10'(CELL_PX);
  localparam logic [11:0] PAL [8] = '{12'h000, 12'hFF0, 12'h0FF, 12'h808,
                                     12'h0F0, 12'h00F, 12'hF00, 12'h08F};

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PENDING, S_COPY} state_t;

  state_t      r_state;
  logic [7:0]  r_idx;
  logic        r_wr_ready;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_shadow [200];
  logic [2:0]  r_display [200];
  logic [1:0]  r_cls;
  logic [7:0]  r_cell;
  logic [4:0]  r_ox;
  logic [4:0]  r_oy;

  logic        w_in_pf;
  logic        w_in_bd;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [3:0]  w_col;
  logic [4:0]  w_row;
  logic [7:0]  w_cell;
  logic [7:0]  w_wr_idx;
  logic        w_wr_ok;
  logic [11:0] w_pix;

  always_comb begin
    w_in_pf  = (hpos >= PX0) && (hpos < PX1) && (vpos >= PY0) && (vpos < PY1);
    w_in_bd  = (hpos >= BX0) && (hpos < BX1) && (vpos >= BY0) && (vpos < BY1);
    w_dx     = w_in_pf ? hpos - PX0 : '0;
    w_dy     = w_in_pf ? vpos - PY0 : '0;
    w_col    = 4'(w_dx / CP);
    w_row    = 5'(w_dy / CP);
    w_cell   = 8'(w_row) * 8'd10 + 8'(w_col);
    w_wr_idx = 8'(wr_row) * 8'd10 + 8'(wr_col);
    w_wr_ok  = wr_en && r_wr_ready && (wr_col < 4'd10) && (wr_row < 5'd20);
    w_pix    = (r_cls == 2'd2) ? (((r_ox == '0) || (r_oy == '0)) ? 12'h333 : PAL[r_display[r_cell]]) :
               (r_cls == 2'd1) ? 12'h888 : 12'h000;
  end

  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) begin
      r_state    <= S_CLEAR;
      r_idx      <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + 8'd1;
          if (r_idx == 8'd199) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        S_IDLE: if (commit) begin
          r_state    <= S_PENDING;
          r_wr_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
        S_PENDING: if ((vpos == VRES) && (hpos == '0)) begin
          r_state <= S_COPY;
          r_idx   <= '0;
        end
        S_COPY: begin
          r_idx <= r_idx + 8'd1;
          if (r_idx == 8'd199) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Board storage has no reset of its own; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk_25_175) begin
    if (r_state == S_CLEAR) begin
      r_shadow[r_idx]  <= '0;
      r_display[r_idx] <= '0;
    end
    if (r_state == S_COPY) r_display[r_idx] <= r_shadow[r_idx];
    if (w_wr_ok) r_shadow[w_wr_idx] <= wr_color;
  end

  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) begin
      r_cls     <= '0;
      r_cell    <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      pixstream <= '0;
    end else begin
      r_cls     <= w_in_pf ? 2'd2 : w_in_bd ? 2'd1 : 2'd0;
      r_cell    <= w_cell;
      r_ox      <= 5'(w_dx % CP);
      r_oy      <= 5'(w_dy % CP);
      pixstream <= w_pix;
    end
  end

  assign wr_ready    = r_wr_ready;
  assign commit_busy = r_busy;
  assign frame_done  = r_done;
endmodule

// File: tb/tb_tetris_board_renderer.sv
// tb_tetris_board_renderer: random and directed stimulus checked every cycle against a behavioural board model.
module tb_tetris_board_renderer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic [11:0] pixstream;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_col = '0;
  logic [4:0]  wr_row = '0;
  logic [2:0]  wr_color = '0;
  logic        wr_ready;
  logic        commit = 1'b0;
  logic        commit_busy;
  logic        frame_done;

  tetris_board_renderer dut (
    .clk_25_175(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .pixstream(pixstream),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color), .wr_ready(wr_ready),
    .commit(commit), .commit_busy(commit_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 clearing, 1 idle, 2 waiting for blanking, 3 publishing (atomic at the end).
  int m_phase = 0;
  int m_cnt = 0;
  int m_pw = 1;
  int m_done = 0;
  int m_pix = 0;
  int m_sx = 0;
  int m_sy = 0;
  int m_sh [200];
  int m_disp [200];
  int pal_t [8] = '{'h000, 'hFF0, 'h0FF, 'h808, 'h0F0, 'h00F, 'hF00, 'h08F};

  function automatic int render(int x, int y);
    if (x >= 220 && x < 420 && y >= 40 && y < 440) begin
      if ((x - 220) % 20 == 0 || (y - 40) % 20 == 0) return 'h333;
      return pal_t[m_disp[((y - 40) / 20) * 10 + (x - 220) / 20]];
    end
    if (x >= 216 && x < 424 && y >= 36 && y < 444) return 'h888;
    return 0;
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_phase = 0; m_cnt = 0; m_done = 0; m_pix = 0; m_sx = 0; m_sy = 0; m_pw = 1;
    end else begin
      m_pix = render(m_sx, m_sy);
      m_sx = int'(hpos);
      m_sy = int'(vpos);
      m_done = 0;
      if (m_pw > 0) m_pw--;
      case (m_phase)
        0: begin
          m_cnt++;
          if (m_cnt == 200) begin
            foreach (m_sh[i]) begin m_sh[i] = 0; m_disp[i] = 0; end
            m_phase = 1;
            m_pw = 1;
          end
        end
        1: begin
          if (wr_en && wr_col < 10 && wr_row < 20) m_sh[int'(wr_row) * 10 + int'(wr_col)] = int'(wr_color);
          if (commit) m_phase = 2;
        end
        2: if (hpos == 0 && vpos == 480) begin m_phase = 3; m_cnt = 200; end
        default: begin
          m_cnt--;
          if (m_cnt == 0) begin m_disp = m_sh; m_phase = 1; m_done = 1; end
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("wr_ready", int'(wr_ready), int'(m_phase == 1));
    chk("commit_busy", int'(commit_busy), int'(m_phase != 1));
    chk("frame_done", int'(frame_done), m_done);
    if (m_phase != 0 && m_pw == 0) chk("pixstream", int'(pixstream), m_pix);
    #2;
  endtask

  task automatic px(input int x, input int y, output int p);
    hpos = 10'(x);
    vpos = 10'(y);
    tick();
    tick();
    p = int'(pixstream);
  endtask

  task automatic wr(input int c, input int r, input int k);
    wr_en = 1'b1; wr_col = 4'(c); wr_row = 5'(r); wr_color = 3'(k);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 1000) begin tick(); n++; end
  endtask

  task automatic publish(input bit twice, output int n, output int pulses);
    commit = 1'b1;
    tick();
    wr_en = 1'b0;
    if (twice) tick();
    commit = 1'b0;
    hpos = '0; vpos = 10'd480;
    tick();
    vpos = 10'd481;
    n = 0;
    while (!frame_done && n < 400) begin tick(); n++; end
    pulses = int'(frame_done);
    repeat (60) begin tick(); pulses += int'(frame_done); end
  endtask

  initial begin
    int n, p, pl;
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    wait_ready(n);
    chk("clear_len", n, 200);
    chk("busy_at_ready", int'(commit_busy), 0);
    px(225, 45, p); chk("px_empty", p, 'h000);

    wr(3, 2, 5); wr(9, 19, 7); wr(10, 0, 3); wr(0, 20, 4);
    publish(1'b0, n, pl);
    chk("copy_len", n, 200);
    chk("done_pulses", pl, 1);
    px(285, 85, p); chk("px_red", p, 'h00F);
    px(280, 85, p); chk("px_grid", p, 'h333);
    px(419, 439, p); chk("px_cell199", p, 'h08F);
    px(225, 65, p); chk("px_col10_dropped", p, 'h000);
    px(219, 50, p); chk("px_border", p, 'h888);
    px(215, 50, p); chk("px_outside", p, 'h000);

    wr(1, 1, 1);
    repeat (600) begin hpos = 10'($urandom_range(200, 440)); vpos = 10'($urandom_range(20, 460)); tick(); end
    px(245, 65, p); chk("px_uncommitted", p, 'h000);

    wr_en = 1'b1; wr_col = 4'd5; wr_row = 5'd5; wr_color = 3'd2;
    publish(1'b0, n, pl);
    chk("copy_len2", n, 200);
    px(325, 145, p); chk("px_write_with_commit", p, 'h0FF);
    px(245, 65, p); chk("px_now_committed", p, 'hFF0);

    publish(1'b1, n, pl);
    chk("double_commit_pulses", pl, 1);

    commit = 1'b1; tick(); commit = 1'b0;
    hpos = '0; vpos = 10'd480; tick(); vpos = 10'd481;
    repeat (101) tick();
    reset = 1'b0;
    #1;
    chk("rst_pix", int'(pixstream), 0);
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_busy", int'(commit_busy), 1);
    chk("rst_done", int'(frame_done), 0);
    repeat (3) tick();
    reset = 1'b1;
    wait_ready(n);
    chk("clear_len2", n, 200);
    px(285, 85, p); chk("px_cleared_a", p, 'h000);
    px(325, 145, p); chk("px_cleared_b", p, 'h000);
    px(419, 439, p); chk("px_cleared_c", p, 'h000);

    for (int i = 0; i < 4000; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_col = 4'($urandom_range(0, 11));
      wr_row = 5'($urandom_range(0, 21));
      wr_color = 3'($urandom_range(0, 7));
      commit = ($urandom_range(0, 149) == 0);
      if (m_phase >= 2) begin
        if (m_phase == 2 && $urandom_range(0, 7) == 0) begin
          hpos = '0; vpos = 10'd480;
        end else begin
          hpos = 10'($urandom_range(0, 1023)); vpos = 10'($urandom_range(480, 1023));
        end
      end else if ($urandom_range(0, 3) != 0) begin
        hpos = 10'($urandom_range(210, 430)); vpos = 10'($urandom_range(30, 450));
      end else begin
        hpos = 10'($urandom_range(0, 1023)); vpos = 10'($urandom_range(0, 1023));
      end
      tick();
    end
    wr_en = 1'b0;
    commit = 1'b0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
